microsequencer: RTL and testbench

- Control-unit sequencer sitting directly downstream of the instruction encoder.
- Holds the current microstate register (6-bit) that addresses the external microstore ROM.
- Each cycle it selects the next state from one of: the encoder's state number, increment, a jump address from the microinstruction, or fixed fetch/hold targets, under condition control.
- Includes a memory-wait watchdog for MOC handshakes.

---
 rtl/microseq_pkg.sv | 32 +++
 rtl/microseq_next_sel.sv | 66 ++++++
 rtl/microsequencer.sv | 75 +++++++
 tb/tb_microsequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: next-state codes, condition
// sources and the microstore entry points of the instruction routines.
package microseq_pkg;

    typedef enum logic [2:0] {
        NS_ENC   = 3'd0,
        NS_INC   = 3'd1,
        NS_JMP   = 3'd2,
        NS_CJMP  = 3'd3,
        NS_CENC  = 3'd4,
        NS_WAIT  = 3'd5,
        NS_FETCH = 3'd6,
        NS_HOLD  = 3'd7
    } ns_sel_e;

    typedef enum logic [1:0] {
        CS_MOC  = 2'd0,
        CS_PASS = 2'd1,
        CS_ONE  = 2'd2,
        CS_ZERO = 2'd3
    } cond_sel_e;

    localparam logic [5:0] ST_ADD_RR    = 6'd10;
    localparam logic [5:0] ST_ADD_IMM   = 6'd11;
    localparam logic [5:0] ST_ADD_SHIFT = 6'd12;
    localparam logic [5:0] ST_CMP       = 6'd13;
    localparam logic [5:0] ST_MOV       = 6'd14;
    localparam logic [5:0] ST_LDR       = 6'd20;
    localparam logic [5:0] ST_STR       = 6'd25;
    localparam logic [5:0] ST_B         = 6'd30;

endpackage

// File: rtl/microseq_next_sel.sv
// Combinational condition mux and next-microaddress mux. The watchdog
// override to the error state is applied by the top level, not here.
module microseq_next_sel
    import microseq_pkg::*;
#(
    parameter int unsigned SW          = 6,
    parameter int unsigned FETCH_STATE = 1
) (
    input  logic [SW-1:0] state,
    input  logic [SW-1:0] enc_state,
    input  logic [2:0]    ns_sel,
    input  logic [SW-1:0] cr_addr,
    input  logic          inv,
    input  logic [1:0]    cond_sel,
    input  logic          moc,
    input  logic          cond_pass,
    output logic [SW-1:0] next_state,
    output logic          hold_wait
);

    localparam logic [SW-1:0] FETCH_ADDR = SW'(FETCH_STATE);

    logic          src_s;
    logic          cond_s;
    logic [SW-1:0] inc_s;

    // Select the raw condition source.
    always_comb begin
        src_s = 1'b0;
        case (cond_sel)
            CS_MOC:  src_s = moc;
            CS_PASS: src_s = cond_pass;
            CS_ONE:  src_s = 1'b1;
            CS_ZERO: src_s = 1'b0;
            default: src_s = 1'b0;
        endcase
    end

    assign cond_s = src_s ^ inv;
    assign inc_s  = state + SW'(1);

    // Next-microaddress decode; undefined codes fall back to HOLD.
    always_comb begin
        next_state = state;
        hold_wait  = 1'b0;
        case (ns_sel)
            NS_ENC:   next_state = enc_state;
            NS_INC:   next_state = inc_s;
            NS_JMP:   next_state = cr_addr;
            NS_CJMP:  next_state = cond_s ? cr_addr : inc_s;
            NS_CENC:  next_state = cond_s ? enc_state : inc_s;
            NS_WAIT: begin
                if (cond_s) begin
                    next_state = inc_s;
                end else begin
                    next_state = state;
                    hold_wait  = 1'b1;
                end
            end
            NS_FETCH: next_state = FETCH_ADDR;
            NS_HOLD:  next_state = state;
            default:  next_state = state;
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer top: microstate register plus the MOC wait watchdog that
// diverts a stalled WAIT to the error state and latches a sticky timeout.
module microsequencer
    import microseq_pkg::*;
#(
    parameter int unsigned SW          = 6,
    parameter int unsigned RESET_STATE = 0,
    parameter int unsigned FETCH_STATE = 1,
    parameter int unsigned ERR_STATE   = 63,
    parameter int unsigned MOC_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [SW-1:0] enc_state,
    input  logic [2:0]    ns_sel,
    input  logic [SW-1:0] cr_addr,
    input  logic          inv,
    input  logic [1:0]    cond_sel,
    input  logic          moc,
    input  logic          cond_pass,
    output logic [SW-1:0] state,
    output logic          waiting,
    output logic          timeout
);

    localparam logic [SW-1:0] RESET_ADDR = SW'(RESET_STATE);
    localparam logic [SW-1:0] ERR_ADDR   = SW'(ERR_STATE);
    localparam logic [7:0]    CNT_LAST   = 8'(MOC_TIMEOUT - 1);

    logic [SW-1:0] state_r;
    logic          timeout_r;
    logic [7:0]    wait_cnt_r;
    logic [SW-1:0] next_s;
    logic          hold_wait_s;

    microseq_next_sel #(
        .SW          (SW),
        .FETCH_STATE (FETCH_STATE)
    ) u_next_sel (
        .state      (state_r),
        .enc_state  (enc_state),
        .ns_sel     (ns_sel),
        .cr_addr    (cr_addr),
        .inv        (inv),
        .cond_sel   (cond_sel),
        .moc        (moc),
        .cond_pass  (cond_pass),
        .next_state (next_s),
        .hold_wait  (hold_wait_s)
    );

    // State register and watchdog; a WAIT that resolves on the deadline cycle is not a holding WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= RESET_ADDR;
            timeout_r  <= 1'b0;
            wait_cnt_r <= 8'd0;
        end else if (hold_wait_s && (wait_cnt_r == CNT_LAST)) begin
            state_r    <= ERR_ADDR;
            timeout_r  <= 1'b1;
            wait_cnt_r <= 8'd0;
        end else if (hold_wait_s) begin
            state_r    <= next_s;
            wait_cnt_r <= (wait_cnt_r == 8'hFF) ? wait_cnt_r : (wait_cnt_r + 8'd1);
        end else begin
            state_r    <= next_s;
            wait_cnt_r <= 8'd0;
        end
    end

    assign state   = state_r;
    assign timeout = timeout_r;
    assign waiting = hold_wait_s & ~reset;

endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for the microsequencer with default parameters.
module tb_microsequencer;
    import microseq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] enc_state;
    logic [2:0] ns_sel;
    logic [5:0] cr_addr;
    logic       inv;
    logic [1:0] cond_sel;
    logic       moc;
    logic       cond_pass;
    logic [5:0] state;
    logic       waiting;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    microsequencer dut (
        .clk       (clk),
        .reset     (reset),
        .enc_state (enc_state),
        .ns_sel    (ns_sel),
        .cr_addr   (cr_addr),
        .inv       (inv),
        .cond_sel  (cond_sel),
        .moc       (moc),
        .cond_pass (cond_pass),
        .state     (state),
        .waiting   (waiting),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enc_state = 6'd0; ns_sel = NS_WAIT; cr_addr = 6'd0;
        inv = 1'b0; cond_sel = CS_ZERO; moc = 1'b0; cond_pass = 1'b0;
        #1;
        chk("waiting_masked_by_reset", {7'd0, waiting}, 8'd0);
        tick();
        chk("reset_state", {2'd0, state}, 8'd0);
        chk("reset_timeout", {7'd0, timeout}, 8'd0);

        reset = 1'b0; ns_sel = NS_INC;
        tick(); chk("inc1", {2'd0, state}, 8'd1);
        tick(); chk("inc2", {2'd0, state}, 8'd2);
        tick(); chk("inc3", {2'd0, state}, 8'd3);
        chk("inc_timeout", {7'd0, timeout}, 8'd0);

        ns_sel = NS_JMP; cr_addr = 6'd1;
        tick(); chk("jmp1", {2'd0, state}, 8'd1);
        ns_sel = NS_ENC; enc_state = ST_LDR;
        tick(); chk("enc_ldr", {2'd0, state}, 8'd20);
        ns_sel = NS_INC;
        tick(); chk("inc21", {2'd0, state}, 8'd21);

        ns_sel = NS_WAIT; cond_sel = CS_MOC; moc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("stall_waiting", {7'd0, waiting}, 8'd1);
            tick(); chk("stall_hold", {2'd0, state}, 8'd21);
        end
        moc = 1'b1;
        #1; chk("moc_waiting", {7'd0, waiting}, 8'd0);
        tick(); chk("moc_advance", {2'd0, state}, 8'd22);

        ns_sel = NS_CJMP; cond_sel = CS_PASS; cr_addr = 6'd40; cond_pass = 1'b1; inv = 1'b0;
        tick(); chk("cjmp_taken", {2'd0, state}, 8'd40);
        inv = 1'b1;
        tick(); chk("cjmp_inv", {2'd0, state}, 8'd41);
        ns_sel = NS_CENC; enc_state = ST_CMP; inv = 1'b0;
        tick(); chk("cenc_taken", {2'd0, state}, 8'd13);
        cond_pass = 1'b0;
        tick(); chk("cenc_not", {2'd0, state}, 8'd14);
        ns_sel = NS_FETCH;
        tick(); chk("fetch", {2'd0, state}, 8'd1);
        ns_sel = NS_JMP; cr_addr = 6'd63;
        tick(); chk("jmp63", {2'd0, state}, 8'd63);
        ns_sel = NS_INC;
        tick(); chk("inc_wrap", {2'd0, state}, 8'd0);
        ns_sel = NS_WAIT; cond_sel = CS_ZERO; inv = 1'b1;
        tick(); chk("wait_const_adv", {2'd0, state}, 8'd1);

        // Deadline race: MOC arrives on the cycle that would time out.
        ns_sel = NS_JMP; cr_addr = ST_B;
        tick(); chk("jmp_b", {2'd0, state}, 8'd30);
        ns_sel = NS_WAIT; cond_sel = CS_MOC; inv = 1'b0; moc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(); chk("race_hold", {2'd0, state}, 8'd30);
        end
        moc = 1'b1;
        tick(); chk("race_advance", {2'd0, state}, 8'd31);
        chk("race_no_timeout", {7'd0, timeout}, 8'd0);

        ns_sel = NS_JMP; cr_addr = ST_STR;
        tick(); chk("jmp_str", {2'd0, state}, 8'd25);
        ns_sel = NS_WAIT; moc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(); chk("to_hold", {2'd0, state}, 8'd25);
            chk("to_flag_low", {7'd0, timeout}, 8'd0);
        end
        tick(); chk("to_err_state", {2'd0, state}, 8'd63);
        chk("to_flag", {7'd0, timeout}, 8'd1);
        ns_sel = NS_INC;
        tick(); chk("to_sticky_state", {2'd0, state}, 8'd0);
        chk("to_sticky", {7'd0, timeout}, 8'd1);
        ns_sel = NS_HOLD;
        tick(); tick(); chk("hold", {2'd0, state}, 8'd0);
        chk("hold_sticky", {7'd0, timeout}, 8'd1);

        // Reset mid-wait must leave no residual count.
        ns_sel = NS_JMP; cr_addr = ST_STR;
        tick(); chk("jmp_str2", {2'd0, state}, 8'd25);
        ns_sel = NS_WAIT;
        for (int i = 0; i < 5; i++) tick();
        chk("prereset_hold", {2'd0, state}, 8'd25);
        reset = 1'b1;
        tick(); chk("midwait_reset", {2'd0, state}, 8'd0);
        chk("midwait_reset_to", {7'd0, timeout}, 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(); chk("post_reset_hold", {2'd0, state}, 8'd0);
        end
        tick(); chk("post_reset_err", {2'd0, state}, 8'd63);
        chk("post_reset_to", {7'd0, timeout}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
